// File: rtl/seq_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_shift_add (with add_sub_4bit datapath adder)
// Brief    : Sequential unsigned shift-and-add multiplier, start/busy/done.
// Revision : 1.0 - initial release
// ============================================================================

// 4-bit ripple adder/subtractor: c_in = 0 adds, c_in = 1 subtracts (a - b).
module add_sub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] w_b_eff;
  logic [4:0] w_carry;

  assign w_b_eff    = b ^ {4{c_in}};
  assign w_carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
  end

  assign c_out = w_carry[4];

endmodule

module seq_mult_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int P_W = $clog2(WIDTH + 1);
  localparam logic [P_W-1:0] C_P_INIT = P_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_c;
  logic [P_W-1:0]     r_p;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;

  logic [WIDTH-1:0]   w_sum;
  logic               w_c_out;
  logic               w_last;

  // Datapath adder: the shared 4-bit block when it fits, a plain add otherwise.
  if (WIDTH == 4) begin : g_team_adder
    add_sub_4bit u_adder (
      .a     (r_a),
      .b     (r_b),
      .c_in  (1'b0),
      .sum   (w_sum),
      .c_out (w_c_out)
    );
  end else begin : g_generic_adder
    assign {w_c_out, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  end

  assign w_last = (r_state == S_SHIFT) && (r_p == '0);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = w_last ? S_IDLE : S_ADD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_b       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_c       <= 1'b0;
      r_p       <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b <= multiplicand;
            r_q <= multiplier;
            r_a <= '0;
            r_c <= 1'b0;
            r_p <= C_P_INIT;
          end
        end
        S_ADD: begin
          if (r_q[0]) begin
            {r_c, r_a} <= {w_c_out, w_sum};
          end else begin
            r_c <= 1'b0;
          end
          r_p <= r_p - 1'b1;
        end
        S_SHIFT: begin
          // The carry from the add step becomes the new accumulator MSB.
          {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[WIDTH-1:1]};
          if (r_p == '0) begin
            r_product <= {r_c, r_a, r_q[WIDTH-1:1]};
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_shift_add
// Brief    : Scoreboard bench: driver queues a*b with its due cycle, monitor checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_shift_add;

  localparam int WIDTH = 4;

  logic               clock = 1'b0;
  logic               reset_b = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   multiplicand = '0;
  logic [WIDTH-1:0]   multiplier = '0;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    int                 due;
  } exp_t;

  exp_t               sb[$];
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;
  logic [2*WIDTH-1:0] last_prod = '0;

  seq_mult_shift_add #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset_b      (reset_b),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: the front entry is due at an exact cycle; anything else is a hold cycle.
  always @(negedge clock) begin
    if (reset_b) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("done_pulse", 16'(done), 16'd1);
        chk("product", 16'(product), 16'(sb[0].prod));
        chk("busy_in_done", 16'(busy), 16'd0);
        last_prod = sb[0].prod;
        void'(sb.pop_front());
      end else begin
        chk("no_spurious_done", 16'(done), 16'd0);
        chk("product_hold", 16'(product), 16'(last_prod));
        chk("busy", 16'(busy), 16'((sb.size() > 0) && (cyc >= sb[0].due - 8)));
      end
    end
  end

  // Start is sampled at the next posedge (cyc+1); done is visible 8 edges later.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    e.prod = (2*WIDTH)'(int'(a) * int'(b));
    e.due  = cyc + 9;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start        = 1'b0;
    multiplicand = WIDTH'($urandom);
    multiplier   = WIDTH'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout at cycle %0d: got no done, expected one within 20 cycles", cyc);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_product", 16'(product), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    reset_b = 1'b1;
    @(posedge clock);
    #1;

    // Directed: basic, carry-heavy and zero-operand cases back to back.
    issue(4'd13, 4'd11); wait_done();
    issue(4'd15, 4'd15); wait_done();
    issue(4'd1,  4'd15); wait_done();
    issue(4'd0,  4'd9);  wait_done();
    issue(4'd9,  4'd0);  wait_done();

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(4'd13, 4'd11);
    repeat (2) @(posedge clock);
    #1;
    multiplicand = 4'd2;
    multiplier   = 4'd2;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done();
    issue(4'd2, 4'd2); wait_done();

    // Asynchronous reset between edges 4 and 5 abandons the operation.
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    issue(4'd7, 4'd7);
    repeat (4) @(posedge clock);
    #3;
    reset_b = 1'b0;
    #1;
    chk("midop_reset_product", 16'(product), 16'd0);
    chk("midop_reset_busy", 16'(busy), 16'd0);
    chk("midop_reset_done", 16'(done), 16'd0);
    sb.delete();
    last_prod = '0;
    @(posedge clock);
    #1;
    reset_b = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    issue(4'd3, 4'd5); wait_done();

    // Exhaustive sweep, each start issued in the previous done cycle.
    for (int i = 0; i < 256; i++) begin
      issue(WIDTH'(i >> 4), WIDTH'(i & 15));
      wait_done();
    end

    // Random operands with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      issue(WIDTH'($urandom), WIDTH'($urandom));
      wait_done();
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
